dip_debouncer: RTL and testbench

DIP_DEBOUNCER -- requirements
Module: dip_debouncer

---
 rtl/dip_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/dip_debouncer.sv | 104 ++++++++++
 tb/tb_dip_debouncer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dip_pkg
//  Description : Shared state encoding and constants for the DIP switch
//                debouncer and the downstream math stage.
//  Revision    : 1.0  initial release
// ============================================================================
package dip_pkg;

    // Debouncer FSM states, 2-bit encoding shared with downstream benches
    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_STABLE   = 2'd1,
        S_SETTLING = 2'd2
    } dip_state_e;

    // Edges after reset release before the candidate register holds a real
    // synchronized sample (two synchronizer stages plus the candidate load).
    localparam logic [1:0] C_FLUSH_DONE = 2'd3;

endpackage : dip_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a WIDTH-bit asynchronous bus,
//                asynchronous active-high reset to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two back-to-back flops to resolve metastability on the raw input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/dip_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : dip_debouncer
//  Description : Debounces a WIDTH-bit DIP switch bank as one vector. A value
//                must hold STABLE_CYCLES synchronized clocks before it is
//                committed to dip_out; dip_changed pulses on each commit.
//  Revision    : 1.0  initial release
// ============================================================================
module dip_debouncer
    import dip_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dip_in,
    output logic [WIDTH-1:0] dip_out,
    output logic             dip_changed,
    output logic             dip_valid
);

    localparam int                 C_CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   r_cand;
    logic [C_CNT_W-1:0] r_cnt;
    logic [1:0]         r_flush;
    dip_state_e         r_state;
    logic [WIDTH-1:0]   r_out;
    logic               r_changed;
    logic               r_valid;

    sync_2ff #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (dip_in),
        .o_q (w_sync)
    );

    // Settle-window FSM: track candidate, count its stability, commit on expiry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand    <= '0;
            r_cnt     <= '0;
            r_flush   <= '0;
            r_state   <= S_INIT;
            r_out     <= '0;
            r_changed <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_changed <= 1'b0;
            if (r_flush != C_FLUSH_DONE) begin
                // Synchronizer still holds reset zeros rather than samples of
                // dip_in; keep reloading so the first window starts from a real
                // sample, giving the same latency whether or not dip_in is zero.
                r_flush <= r_flush + 2'd1;
                r_cand  <= w_sync;
                r_cnt   <= '0;
            end else if (w_sync != r_cand) begin
                // Any bit change restarts the whole window
                r_cand <= w_sync;
                r_cnt  <= '0;
                if (r_state != S_INIT) begin
                    r_state <= S_SETTLING;
                end
            end else begin
                case (r_state)
                    S_STABLE: begin
                        r_cnt <= '0;
                    end
                    S_INIT, S_SETTLING: begin
                        if ((r_state == S_SETTLING) && (r_cand == r_out)) begin
                            // Bounced back to the committed value: nothing to report
                            r_state <= S_STABLE;
                            r_cnt   <= '0;
                        end else if (r_cnt == C_CNT_MAX) begin
                            r_out     <= r_cand;
                            r_changed <= 1'b1;
                            r_valid   <= 1'b1;
                            r_state   <= S_STABLE;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_INIT;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign dip_out     = r_out;
    assign dip_changed = r_changed;
    assign dip_valid   = r_valid;

endmodule : dip_debouncer
`default_nettype wire

// File: tb/tb_dip_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dip_debouncer
//  Description : Self-checking bench for dip_debouncer (WIDTH=8,
//                STABLE_CYCLES=4): directed vector table, hand-written corner
//                sequences and randomized stimulus against a sample-history
//                reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dip_debouncer;
    import dip_pkg::*;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] dip_in = '0;
    logic [W-1:0] dip_out;
    logic         dip_changed;
    logic         dip_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dip_debouncer #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dip_in      (dip_in),
        .dip_out     (dip_out),
        .dip_changed (dip_changed),
        .dip_valid   (dip_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: commit V at edge t when the samples of dip_in taken at
    // edges t-2-S .. t-2 (since reset release) are all V and V is new or nothing
    // has been committed yet.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_out;
    logic         m_chg;
    logic         m_valid;

    task automatic model_reset();
        m_hist.delete();
        m_out   = '0;
        m_chg   = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_step(input logic [W-1:0] v);
        int           t;
        bit           run;
        logic [W-1:0] val;
        m_hist.push_back(v);
        t     = m_hist.size() - 1;
        m_chg = 1'b0;
        if (t - 2 - S >= 0) begin
            val = m_hist[t-2];
            run = 1'b1;
            for (int k = t - 2 - S; k <= t - 2; k++) begin
                if (m_hist[k] !== val) run = 1'b0;
            end
            if (run && (!m_valid || val != m_out)) begin
                m_out   = val;
                m_chg   = 1'b1;
                m_valid = 1'b1;
            end
        end
    endtask

    // All stimulus tasks start and end just after a falling edge.
    task automatic cycle(input logic [W-1:0] v);
        dip_in = v;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic settle_to_negedge();
        @(negedge clk);
    endtask

    task automatic assert_reset();
        rst = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        bit           rst;
        logic [W-1:0] din;
        logic [W-1:0] out;
        bit           chg;
        bit           val;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit r, input logic [W-1:0] d, input logic [W-1:0] o,
                                input bit c, input bit v);
        vec_t e;
        e.rst = r; e.din = d; e.out = o; e.chg = c; e.val = v;
        vecs.push_back(e);
    endfunction

    initial begin
        int           bad;
        int           pulses;
        int           first_edge;
        bit           prev_chg;
        logic [W-1:0] v;
        logic [W-1:0] pick[4];
        int           hold;

        // Reset, 0x00 held: commit of zeros at edge 6 after release
        add(1, 8'h00, 8'h00, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 8'h00, 8'h00, 0, 0);
        add(0, 8'h00, 8'h00, 1, 1);
        add(0, 8'h00, 8'h00, 0, 1);
        // Step to 0x5A: commit at edge 6 after sampling
        for (int i = 0; i < 6; i++) add(0, 8'h5A, 8'h00, 0, 1);
        add(0, 8'h5A, 8'h5A, 1, 1);
        add(0, 8'h5A, 8'h5A, 0, 1);
        // Three-cycle glitch to 0xFF never reaches the output
        for (int i = 0; i < 3; i++) add(0, 8'hFF, 8'h5A, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 8'h5A, 8'h5A, 0, 1);

        settle_to_negedge();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                assert_reset();
                check($sformatf("vec%0d_out", i), 32'(dip_out), 32'(vecs[i].out));
                check($sformatf("vec%0d_chg", i), 32'(dip_changed), 32'(vecs[i].chg));
                check($sformatf("vec%0d_val", i), 32'(dip_valid), 32'(vecs[i].val));
                release_reset();
            end else begin
                cycle(vecs[i].din);
                check($sformatf("vec%0d_out", i), 32'(dip_out), 32'(vecs[i].out));
                check($sformatf("vec%0d_chg", i), 32'(dip_changed), 32'(vecs[i].chg));
                check($sformatf("vec%0d_val", i), 32'(dip_valid), 32'(vecs[i].val));
                settle_to_negedge();
            end
        end
        check("glitch_state_stable", 32'(dut.r_state), 32'(S_STABLE));

        // Toggle 0x5B/0x5A every 2 cycles for 40 cycles, then hold 0x5B
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cycle((((i / 2) % 2) == 0) ? 8'h5B : 8'h5A);
            if (dip_out !== 8'h5A || dip_changed !== 1'b0) bad++;
            settle_to_negedge();
        end
        check("toggle_no_change", 32'(bad), 32'd0);
        pulses = 0;
        first_edge = -1;
        for (int e = 0; e < 10; e++) begin
            cycle(8'h5B);
            if (dip_changed === 1'b1) pulses++;
            if (first_edge < 0 && dip_out === 8'h5B) first_edge = e;
            settle_to_negedge();
        end
        check("toggle_commit_edge", 32'(first_edge), 32'd6);
        check("toggle_pulses", 32'(pulses), 32'd1);
        check("toggle_out", 32'(dip_out), 32'h5B);

        // Step to 0x81, reset mid-settle, then full window after release
        for (int e = 0; e < 4; e++) begin
            cycle(8'h81);
            settle_to_negedge();
        end
        check("midsettle_state", 32'(dut.r_state), 32'(S_SETTLING));
        assert_reset();
        check("rst_out", 32'(dip_out), 32'h00);
        check("rst_chg", 32'(dip_changed), 32'd0);
        check("rst_val", 32'(dip_valid), 32'd0);
        release_reset();
        bad = 0;
        pulses = 0;
        first_edge = -1;
        for (int e = 0; e < 9; e++) begin
            cycle(8'h81);
            if (dip_changed === 1'b1) begin
                pulses++;
                if (first_edge < 0) first_edge = e;
            end
            if (e < 6 && (dip_out !== 8'h00 || dip_valid !== 1'b0)) bad++;
            settle_to_negedge();
        end
        check("rst_pre_commit_quiet", 32'(bad), 32'd0);
        check("rst_commit_edge", 32'(first_edge), 32'd6);
        check("rst_pulses", 32'(pulses), 32'd1);
        check("rst_commit_out", 32'(dip_out), 32'h81);
        check("rst_commit_val", 32'(dip_valid), 32'd1);

        // Randomized holds of 1..10 cycles against the reference model
        pick[0] = 8'h00; pick[1] = 8'h5A; pick[2] = 8'h5B; pick[3] = 8'hFF;
        assert_reset();
        release_reset();
        prev_chg = 1'b0;
        hold = 0;
        v = '0;
        for (int c = 0; c < 10000; c++) begin
            if (hold == 0) begin
                v    = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 3)] : 8'($urandom);
                hold = $urandom_range(1, 10);
            end
            hold--;
            cycle(v);
            check("rand_out", 32'(dip_out), 32'(m_out));
            check("rand_chg", 32'(dip_changed), 32'(m_chg));
            check("rand_val", 32'(dip_valid), 32'(m_valid));
            check("rand_no_b2b", 32'(prev_chg && dip_changed), 32'd0);
            prev_chg = dip_changed;
            settle_to_negedge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dip_debouncer
`default_nettype wire
